// File: rtl/mult_pkg.sv
// Shared constants, register map and state encodings for the multiplier operand DMA.
package mult_pkg;

    localparam logic [31:0] MultAddrDefault = 32'h0004_0000;

    localparam logic [3:0] RegSrc  = 4'h0;
    localparam logic [3:0] RegDst  = 4'h4;
    localparam logic [3:0] RegLen  = 4'h8;
    localparam logic [3:0] RegCtrl = 4'hC;

    localparam int unsigned CtrlStart    = 0;
    localparam int unsigned CtrlIen      = 1;
    localparam int unsigned CtrlClear    = 2;
    localparam int unsigned StatBusy     = 0;
    localparam int unsigned StatIen      = 1;
    localparam int unsigned StatDone     = 2;
    localparam int unsigned StatErr      = 3;
    localparam int unsigned StatCountLsb = 16;
    localparam int unsigned StatCountW   = 16;

    typedef enum logic [2:0] {
        DmaIdle,
        DmaRdOp,
        DmaWrMul,
        DmaRdRes,
        DmaWrDst
    } dma_state_e;

    typedef enum logic [1:0] {
        HostIdle,
        HostReq,
        HostWait
    } host_state_e;

    // Byte-enable merge of a write into the current register value.
    function automatic logic [31:0] merge_be(input logic [31:0] cur, input logic [31:0] wdata,
                                             input logic [3:0] be);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mult_dma_host_if.sv
// Single-outstanding bus master: holds a request until granted, then waits for the response.
module mult_dma_host_if
    import mult_pkg::*;
#(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cmd_valid,
    input  logic [AddressWidth-1:0]   cmd_addr,
    input  logic                      cmd_we,
    input  logic [DataWidth-1:0]      cmd_wdata,
    output logic                      rsp_valid_c,
    output logic [DataWidth-1:0]      rsp_rdata_c,
    output logic                      rsp_err_c,
    output logic                      host_req,
    input  logic                      host_gnt,
    output logic [AddressWidth-1:0]   host_addr,
    output logic                      host_we,
    output logic [DataWidth/8-1:0]    host_be,
    output logic [DataWidth-1:0]      host_wdata,
    input  logic                      host_rvalid,
    input  logic [DataWidth-1:0]      host_rdata,
    input  logic                      host_err
);

    host_state_e               state_q, state_d;
    logic                      req_d;
    logic [AddressWidth-1:0]   addr_d;
    logic                      we_d;
    logic [DataWidth-1:0]      wdata_d;
    logic                      accept_c;

    // A new command may chain onto the cycle its predecessor's response arrives.
    assign accept_c    = cmd_valid && ((state_q == HostIdle) ||
                                       ((state_q == HostWait) && host_rvalid));
    assign rsp_valid_c = (state_q == HostWait) && host_rvalid;
    assign rsp_rdata_c = host_rdata;
    assign rsp_err_c   = host_err;
    assign host_be     = {(DataWidth/8){1'b1}};

    // Next-state and request payload.
    always_comb begin
        state_d = state_q;
        req_d   = host_req;
        addr_d  = host_addr;
        we_d    = host_we;
        wdata_d = host_wdata;
        case (state_q)
            HostIdle: ;
            HostReq: begin
                if (host_gnt) begin
                    state_d = HostWait;
                    req_d   = 1'b0;
                end
            end
            HostWait: begin
                if (host_rvalid) state_d = HostIdle;
            end
            default: state_d = HostIdle;
        endcase
        if (accept_c) begin
            state_d = HostReq;
            req_d   = 1'b1;
            addr_d  = cmd_addr;
            we_d    = cmd_we;
            wdata_d = cmd_wdata;
        end
    end

    // State and registered master outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= HostIdle;
            host_req   <= 1'b0;
            host_addr  <= '0;
            host_we    <= 1'b0;
            host_wdata <= '0;
        end else begin
            state_q    <= state_d;
            host_req   <= req_d;
            host_addr  <= addr_d;
            host_we    <= we_d;
            host_wdata <= wdata_d;
        end
    end

endmodule

// File: rtl/mult_dma.sv
// Operand feeder: streams packed operand words through the multiplier into a destination array.
module mult_dma
    import mult_pkg::*;
#(
    parameter int unsigned DataWidth          = 32,
    parameter int unsigned AddressWidth       = 32,
    parameter logic [AddressWidth-1:0] MultAddr = AddressWidth'(MultAddrDefault),
    parameter int unsigned LenWidth           = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      dma_req_i,
    input  logic [AddressWidth-1:0]   dma_addr_i,
    input  logic                      dma_we_i,
    input  logic [DataWidth/8-1:0]    dma_be_i,
    input  logic [DataWidth-1:0]      dma_wdata_i,
    output logic                      dma_rvalid_o,
    output logic [DataWidth-1:0]      dma_rdata_o,
    output logic                      dma_err_o,
    output logic                      host_req_o,
    input  logic                      host_gnt_i,
    output logic [AddressWidth-1:0]   host_addr_o,
    output logic                      host_we_o,
    output logic [DataWidth/8-1:0]    host_be_o,
    output logic [DataWidth-1:0]      host_wdata_o,
    input  logic                      host_rvalid_i,
    input  logic [DataWidth-1:0]      host_rdata_i,
    input  logic                      host_err_i,
    output logic                      irq_o
);

    localparam logic [AddressWidth-1:0] PtrStep = AddressWidth'(4);

    dma_state_e                state_q, state_d;
    logic [AddressWidth-1:0]   src_q, src_d, dst_q, dst_d;
    logic [AddressWidth-1:0]   src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
    logic [LenWidth-1:0]       len_q, len_d, cnt_q, cnt_d;
    logic                      ien_q, ien_d, done_q, done_d, err_q, err_d, irq_d;
    logic                      cmd_valid_c, cmd_we_c;
    logic [AddressWidth-1:0]   cmd_addr_c;
    logic [DataWidth-1:0]      cmd_wdata_c;
    logic                      rsp_valid_c, rsp_err_c;
    logic [DataWidth-1:0]      rsp_rdata_c;
    logic                      slv_hit_c, slv_wr_c, busy_c;
    logic [3:0]                slv_off_c;
    logic [DataWidth-1:0]      slv_rdata_c, status_c;

    // Only the four word registers at the bottom of the window decode.
    assign slv_off_c = dma_addr_i[3:0];
    assign slv_hit_c = (dma_addr_i[AddressWidth-1:4] == '0) && (dma_addr_i[1:0] == 2'b00);
    assign slv_wr_c  = dma_req_i && dma_we_i && slv_hit_c;
    assign busy_c    = (state_q != DmaIdle);

    mult_dma_host_if #(
        .DataWidth   (DataWidth),
        .AddressWidth(AddressWidth)
    ) u_host_if (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .cmd_valid  (cmd_valid_c),
        .cmd_addr   (cmd_addr_c),
        .cmd_we     (cmd_we_c),
        .cmd_wdata  (cmd_wdata_c),
        .rsp_valid_c(rsp_valid_c),
        .rsp_rdata_c(rsp_rdata_c),
        .rsp_err_c  (rsp_err_c),
        .host_req   (host_req_o),
        .host_gnt   (host_gnt_i),
        .host_addr  (host_addr_o),
        .host_we    (host_we_o),
        .host_be    (host_be_o),
        .host_wdata (host_wdata_o),
        .host_rvalid(host_rvalid_i),
        .host_rdata (host_rdata_i),
        .host_err   (host_err_i)
    );

    // Status word and slave read mux.
    always_comb begin
        status_c                             = '0;
        status_c[StatBusy]                   = busy_c;
        status_c[StatIen]                    = ien_q;
        status_c[StatDone]                   = done_q;
        status_c[StatErr]                    = err_q;
        status_c[StatCountLsb +: StatCountW] = StatCountW'(cnt_q);
        slv_rdata_c = '0;
        if (slv_hit_c) begin
            case (slv_off_c)
                RegSrc:  slv_rdata_c = DataWidth'(src_q);
                RegDst:  slv_rdata_c = DataWidth'(dst_q);
                RegLen:  slv_rdata_c = DataWidth'(len_q);
                RegCtrl: slv_rdata_c = status_c;
                default: slv_rdata_c = '0;
            endcase
        end
    end

    // Register writes, transfer sequencing and next command issue.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        cnt_d       = cnt_q;
        ien_d       = ien_q;
        done_d      = done_q;
        err_d       = err_q;
        irq_d       = 1'b0;
        cmd_valid_c = 1'b0;
        cmd_addr_c  = '0;
        cmd_we_c    = 1'b0;
        cmd_wdata_c = '0;

        if (slv_wr_c && !busy_c) begin
            case (slv_off_c)
                RegSrc:  src_d = AddressWidth'(merge_be(32'(src_q), dma_wdata_i, dma_be_i));
                RegDst:  dst_d = AddressWidth'(merge_be(32'(dst_q), dma_wdata_i, dma_be_i));
                RegLen:  len_d = LenWidth'(merge_be(32'(len_q), dma_wdata_i, dma_be_i));
                default: ;
            endcase
        end

        if (slv_wr_c && (slv_off_c == RegCtrl) && dma_be_i[0]) begin
            ien_d = dma_wdata_i[CtrlIen];
            if (dma_wdata_i[CtrlClear]) begin
                done_d = 1'b0;
                err_d  = 1'b0;
            end
            if (dma_wdata_i[CtrlStart] && !busy_c) begin
                if (len_q != '0) begin
                    src_ptr_d   = src_q;
                    dst_ptr_d   = dst_q;
                    cnt_d       = len_q;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    state_d     = DmaRdOp;
                    cmd_valid_c = 1'b1;
                    cmd_addr_c  = src_q;
                end else begin
                    done_d = 1'b1;
                end
            end
        end

        if (rsp_valid_c) begin
            if (rsp_err_c) begin
                state_d = DmaIdle;
                err_d   = 1'b1;
                done_d  = 1'b0;
            end else begin
                case (state_q)
                    DmaRdOp: begin
                        state_d     = DmaWrMul;
                        cmd_valid_c = 1'b1;
                        cmd_addr_c  = MultAddr;
                        cmd_we_c    = 1'b1;
                        cmd_wdata_c = rsp_rdata_c;
                    end
                    DmaWrMul: begin
                        state_d     = DmaRdRes;
                        cmd_valid_c = 1'b1;
                        cmd_addr_c  = MultAddr;
                    end
                    DmaRdRes: begin
                        state_d     = DmaWrDst;
                        cmd_valid_c = 1'b1;
                        cmd_addr_c  = dst_ptr_q;
                        cmd_we_c    = 1'b1;
                        cmd_wdata_c = rsp_rdata_c;
                    end
                    DmaWrDst: begin
                        src_ptr_d = src_ptr_q + PtrStep;
                        dst_ptr_d = dst_ptr_q + PtrStep;
                        cnt_d     = cnt_q - LenWidth'(1);
                        if (cnt_q != LenWidth'(1)) begin
                            state_d     = DmaRdOp;
                            cmd_valid_c = 1'b1;
                            cmd_addr_c  = src_ptr_q + PtrStep;
                        end else begin
                            state_d = DmaIdle;
                            done_d  = 1'b1;
                        end
                    end
                    default: state_d = DmaIdle;
                endcase
            end
        end

        irq_d = ien_d && (done_d || err_d);
    end

    // Control state, configuration and working registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= DmaIdle;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            cnt_q     <= '0;
            ien_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            cnt_q     <= cnt_d;
            ien_q     <= ien_d;
            done_q    <= done_d;
            err_q     <= err_d;
            irq_o     <= irq_d;
        end
    end

    // Slave response one cycle after each request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dma_rvalid_o <= 1'b0;
            dma_rdata_o  <= '0;
            dma_err_o    <= 1'b0;
        end else begin
            dma_rvalid_o <= dma_req_i;
            if (dma_req_i) begin
                dma_rdata_o <= slv_rdata_c;
                dma_err_o   <= !slv_hit_c;
            end
        end
    end

endmodule

// File: tb/tb_mult_dma.sv
// Randomized bench for mult_dma: memory + multiplier bus model, transfer-level reference.
`timescale 1ns/1ps
module tb_mult_dma;

    localparam logic [31:0] MULT = 32'h0004_0000;
    localparam logic [31:0] A_SRC = 32'h0, A_DST = 32'h4, A_LEN = 32'h8, A_CTRL = 32'hC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [3:0]  dma_be;
    logic        dma_rvalid, dma_err;
    logic        host_req, host_gnt, host_we, host_rvalid, host_err;
    logic [31:0] host_addr, host_wdata, host_rdata;
    logic [3:0]  host_be;
    logic        irq;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int unsigned cyc;
    } txn_t;

    txn_t        log_q[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] ops [8];
    logic [31:0] mult_reg = '0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          force_stall = -1;
    int unsigned max_stall = 0;
    int          stall_left = 0;
    int          inj_err = -1;
    int          txn_idx = 0;
    int unsigned req_cycles = 0;

    mult_dma dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .dma_req_i    (dma_req),
        .dma_addr_i   (dma_addr),
        .dma_we_i     (dma_we),
        .dma_be_i     (dma_be),
        .dma_wdata_i  (dma_wdata),
        .dma_rvalid_o (dma_rvalid),
        .dma_rdata_o  (dma_rdata),
        .dma_err_o    (dma_err),
        .host_req_o   (host_req),
        .host_gnt_i   (host_gnt),
        .host_addr_o  (host_addr),
        .host_we_o    (host_we),
        .host_be_o    (host_be),
        .host_wdata_o (host_wdata),
        .host_rvalid_i(host_rvalid),
        .host_rdata_i (host_rdata),
        .host_err_i   (host_err),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic int pick_stall();
        return (force_stall >= 0) ? force_stall : int'($urandom_range(0, max_stall));
    endfunction

    // Device bus model: random grant delay, response the cycle after grant.
    initial begin : responder
        logic [31:0] pend_data, first_addr, first_wdata;
        logic        pend_err, first_we, pending, req_seen;
        pending = 1'b0; req_seen = 1'b0; pend_data = '0; pend_err = 1'b0;
        first_addr = '0; first_wdata = '0; first_we = 1'b0;
        host_gnt = 1'b0; host_rvalid = 1'b0; host_err = 1'b0; host_rdata = '0;
        forever begin
            @(negedge clk);
            host_gnt = 1'b0; host_rvalid = 1'b0; host_err = 1'b0; host_rdata = '0;
            if (!rst_n) begin
                pending  = 1'b0;
                req_seen = 1'b0;
            end else begin
                if (host_req) req_cycles++;
                if (pending) begin
                    host_rvalid = 1'b1;
                    host_rdata  = pend_data;
                    host_err    = pend_err;
                    pending     = 1'b0;
                end else if (host_req) begin
                    if (!req_seen) begin
                        req_seen = 1'b1; first_addr = host_addr;
                        first_we = host_we; first_wdata = host_wdata;
                    end
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        txn_t t;
                        chk("req_addr_stable", host_addr, first_addr);
                        chk("req_we_stable", 32'(host_we), 32'(first_we));
                        chk("req_wdata_stable", host_wdata, first_wdata);
                        chk("host_be", 32'(host_be), 32'hF);
                        host_gnt = 1'b1;
                        t.addr = host_addr; t.we = host_we; t.wdata = host_wdata; t.cyc = cyc;
                        log_q.push_back(t);
                        if (host_we) begin
                            if (host_addr == MULT) mult_reg = host_wdata;
                            else mem[host_addr] = host_wdata;
                            pend_data = '0;
                        end else if (host_addr == MULT) begin
                            pend_data = 32'(mult_reg[31:16]) * 32'(mult_reg[15:0]);
                        end else begin
                            pend_data = mem_rd(host_addr);
                        end
                        pend_err   = (txn_idx == inj_err);
                        pending    = 1'b1;
                        req_seen   = 1'b0;
                        txn_idx++;
                        stall_left = pick_stall();
                    end
                end
            end
        end
    end

    task automatic cfg_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic [31:0] rdata, output logic err);
        @(negedge clk);
        dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_be = be;
        @(negedge clk);
        dma_req = 1'b0; dma_we = 1'b0;
        chk("slv_rvalid", 32'(dma_rvalid), 32'd1);
        rdata = dma_rdata;
        err   = dma_err;
    endtask

    task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic        e;
        cfg_access(1'b1, addr, data, 4'hF, rd, e);
        chk("wr_err", 32'(e), 32'd0);
    endtask

    task automatic cfg_read(input logic [31:0] addr, output logic [31:0] data);
        logic e;
        cfg_access(1'b0, addr, '0, 4'hF, data, e);
        chk("rd_err", 32'(e), 32'd0);
    endtask

    task automatic wait_idle(output logic [31:0] st);
        st = 32'hFFFF_FFFF;
        for (int i = 0; i < 500; i++) begin
            cfg_read(A_CTRL, st);
            if (!st[0]) break;
        end
        chk("busy_clears", 32'(st[0]), 32'd0);
    endtask

    task automatic expect_txn(input int k, input logic [31:0] addr, input logic we,
                              input logic [31:0] wdata);
        if (k >= log_q.size()) begin
            chk("txn_count", 32'(log_q.size()), 32'(k + 1));
        end else begin
            chk("txn_addr", log_q[k].addr, addr);
            chk("txn_we", 32'(log_q[k].we), 32'(we));
            if (we) chk("txn_wdata", log_q[k].wdata, wdata);
        end
    endtask

    // One programmed transfer; with err_txn < 0 the full result is checked here.
    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input int err_txn);
        logic [31:0] st, rd;
        logic        e;
        for (int i = 0; i < len; i++) begin
            mem[src + 32'(4 * i)] = ops[i];
            mem[dst + 32'(4 * i)] = 32'hDEAD_BEEF;
        end
        log_q.delete();
        txn_idx    = 0;
        inj_err    = err_txn;
        stall_left = pick_stall();
        cfg_write(A_SRC, src);
        cfg_write(A_DST, dst);
        cfg_write(A_LEN, 32'(len));
        cfg_write(A_CTRL, 32'h7);
        cfg_access(1'b1, A_DST, 32'h0000_BAD0, 4'hF, rd, e);
        chk("busy_wr_noerr", 32'(e), 32'd0);
        wait_idle(st);
        cfg_read(A_DST, rd);
        chk("dst_reg_held", rd, dst);
        if (err_txn < 0) begin
            chk("st_done", 32'(st[2]), 32'd1);
            chk("st_err", 32'(st[3]), 32'd0);
            chk("st_count", 32'(st[31:16]), 32'd0);
            chk("irq_done", 32'(irq), 32'd1);
            chk("txn_total", 32'(log_q.size()), 32'(4 * len));
            for (int i = 0; i < len; i++) begin
                int unsigned a, b, p;
                a = 32'(ops[i][31:16]);
                b = 32'(ops[i][15:0]);
                p = a * b;
                expect_txn(4 * i + 0, src + 32'(4 * i), 1'b0, '0);
                expect_txn(4 * i + 1, MULT, 1'b1, ops[i]);
                expect_txn(4 * i + 2, MULT, 1'b0, '0);
                expect_txn(4 * i + 3, dst + 32'(4 * i), 1'b1, p);
                chk("dst_mem", mem_rd(dst + 32'(4 * i)), p);
            end
            if (force_stall == 0 && len > 1 && log_q.size() > 4)
                chk("elem_latency", log_q[4].cyc - log_q[0].cyc, 32'd8);
        end
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] rd, st;
        logic        e, found;
        int unsigned rq0;
        rst_n = 1'b0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; dma_be = '0;
        repeat (3) @(negedge clk);
        chk("rst_host_req", 32'(host_req), 32'd0);
        chk("rst_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        cfg_read(A_CTRL, rd); chk("rst_status", rd, 32'h0);
        cfg_read(A_LEN, rd);  chk("rst_len", rd, 32'h0);

        // Byte-merged writes and undecoded offsets.
        cfg_write(A_SRC, 32'h1122_3344);
        cfg_access(1'b1, A_SRC, 32'hAABB_CCDD, 4'b0010, rd, e);
        cfg_read(A_SRC, rd); chk("src_byte_merge", rd, 32'h1122_CC44);
        cfg_access(1'b0, 32'h10, '0, 4'hF, rd, e);
        chk("bad_off_err", 32'(e), 32'd1);
        chk("bad_off_rdata", rd, 32'h0);

        // Single element behind a 10-cycle grant stall.
        force_stall = 10;
        ops[0] = 32'h0003_0004;
        run_xfer(32'h100, 32'h200, 1, -1);

        // Corner operands with zero-wait bus.
        force_stall = 0;
        ops[0] = 32'hFFFF_FFFF; ops[1] = 32'h0000_0005; ops[2] = 32'h0002_0007;
        run_xfer(32'h400, 32'h800, 3, -1);

        // Source pointer wraps past the top of the address space.
        ops[0] = 32'h0010_0010; ops[1] = 32'h1234_0002; ops[2] = 32'h0003_FFFF;
        run_xfer(32'hFFFF_FFF8, 32'h3000, 3, -1);

        // Random transfers.
        force_stall = -1;
        for (int r = 0; r < 6; r++) begin
            int len;
            max_stall = $urandom_range(0, 3);
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 5))
                    0:       ops[i] = 32'hFFFF_FFFF;
                    1:       ops[i] = {16'h0, 16'($urandom)};
                    default: ops[i] = $urandom;
                endcase
            end
            run_xfer(32'h0001_0000 + ($urandom_range(0, 255) << 5),
                     32'h0002_0000 + ($urandom_range(0, 255) << 5), len, -1);
        end

        // Zero-length start: done and irq without bus traffic, then clear.
        cfg_write(A_CTRL, 32'h4);
        chk("irq_cleared", 32'(irq), 32'd0);
        cfg_write(A_LEN, 32'h0);
        rq0 = req_cycles;
        cfg_write(A_CTRL, 32'h3);
        chk("len0_irq", 32'(irq), 32'd1);
        repeat (4) @(negedge clk);
        chk("len0_no_req", req_cycles, rq0);
        cfg_read(A_CTRL, rd);
        chk("len0_status", rd, 32'h0000_0006);
        cfg_write(A_CTRL, 32'h6);
        chk("len0_irq_clear", 32'(irq), 32'd0);

        // Bus error on the product read of element 2 of 4.
        force_stall = 0;
        for (int i = 0; i < 4; i++) ops[i] = 32'h0001_0001 + 32'(i);
        run_xfer(32'h5000, 32'h6000, 4, 6);
        cfg_read(A_CTRL, st);
        chk("abort_busy", 32'(st[0]), 32'd0);
        chk("abort_err", 32'(st[3]), 32'd1);
        chk("abort_done", 32'(st[2]), 32'd0);
        chk("abort_count", 32'(st[31:16]), 32'd3);
        chk("abort_irq", 32'(irq), 32'd1);
        chk("abort_txns", 32'(log_q.size()), 32'd7);

        // Reset while the multiplier write is pending.
        force_stall = 5;
        ops[0] = 32'h0009_0009; ops[1] = 32'h0002_0002;
        mem[32'h7000] = ops[0]; mem[32'h7004] = ops[1];
        stall_left = 0;
        cfg_write(A_SRC, 32'h7000);
        cfg_write(A_DST, 32'h7100);
        cfg_write(A_LEN, 32'd2);
        cfg_write(A_CTRL, 32'h7);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (host_req && host_we && host_addr == MULT) found = 1'b1;
        end
        chk("saw_wr_mul", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 32'(host_req), 32'd0);
        chk("rst_mid_irq", 32'(irq), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        force_stall = -1;
        cfg_read(A_CTRL, rd); chk("rst_mid_status", rd, 32'h0);
        cfg_read(A_SRC, rd);  chk("rst_mid_src", rd, 32'h0);
        cfg_access(1'b0, 32'h10, '0, 4'hF, rd, e);
        chk("rst_bad_err", 32'(e), 32'd1);
        chk("rst_bad_rdata", rd, 32'h0);
        cfg_access(1'b1, 32'h14, 32'h1, 4'hF, rd, e);
        chk("bad_wr_err", 32'(e), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
